// File: rtl/control_if.sv
// Shared types for the RV32I multicycle control unit, plus the memory-port
// bundle between the control unit and the memory interface.
package control_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
        alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        add = 3'b000, sll = 3'b001, slt = 3'b010, sltu = 3'b011,
        axor = 3'b100, sr = 3'b101, aor = 3'b110, aand = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        lb = 3'b000, lh = 3'b001, lw = 3'b010, lbu = 3'b100, lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [1:0] {
        pcmux_pc_plus4, pcmux_alu_out, pcmux_alu_mod2
    } pcmux_sel_t;

    typedef enum logic [3:0] {
        rfmux_alu_out, rfmux_br_en, rfmux_u_imm, rfmux_lw, rfmux_pc_plus4,
        rfmux_lb, rfmux_lbu, rfmux_lh, rfmux_lhu
    } regfilemux_sel_t;

    typedef enum logic {
        marmux_pc_out, marmux_alu_out
    } marmux_sel_t;

    typedef enum logic {
        alumux1_rs1_out, alumux1_pc_out
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm, alumux2_u_imm, alumux2_b_imm, alumux2_s_imm, alumux2_j_imm, alumux2_rs2_out
    } alumux2_sel_t;

    typedef enum logic {
        cmpmux_rs2_out, cmpmux_i_imm
    } cmpmux_sel_t;

endpackage

// Memory handshake bundle: control drives strobes and byte masks, memory
// answers with mem_resp; MAR contents come back for lane selection.
interface control_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  read_mask;
    logic [3:0]  write_mask;
    logic        mem_resp;
    logic [31:0] mem_addr_unaligned;

    modport master (
        output mem_read, mem_write, read_mask, write_mask,
        input  mem_resp, mem_addr_unaligned
    );

    modport slave (
        input  mem_read, mem_write, read_mask, write_mask,
        output mem_resp, mem_addr_unaligned
    );
endinterface

// File: rtl/control.sv
// Multicycle RV32I sequencer: walks each instruction through fetch, decode,
// execute, memory and writeback, driving every datapath control signal.
module control
    import control_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            br_en,
    control_if.master       bus,
    output logic            load_pc,
    output logic            load_ir,
    output logic            load_regfile,
    output logic            load_mar,
    output logic            load_mdr,
    output logic            load_data_out,
    output pcmux_sel_t      pcmux_sel,
    output regfilemux_sel_t regfilemux_sel,
    output marmux_sel_t     marmux_sel,
    output alumux1_sel_t    alumux1_sel,
    output alumux2_sel_t    alumux2_sel,
    output cmpmux_sel_t     cmpmux_sel,
    output alu_ops          aluop,
    output branch_funct3_t  cmpop
);

    typedef enum logic [4:0] {
        FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC, BR,
        CALC_LD, CALC_ST, LD1, LD2, ST1, ST2, JAL, JALR
    } state_t;

    state_t state, next_state;

    logic unused_bits;
    assign unused_bits = ^{funct7[6], funct7[4:0], bus.mem_addr_unaligned[31:2]};

    // Byte-lane mask from access size (funct3[1:0]) and address offset;
    // the shift truncates to 4 bits, so misaligned halves lose upper lanes.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = 4'b0011 << off;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // State register; reset parks the sequencer at the start of fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH1;
        else      state <= next_state;
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        next_state     = state;
        load_pc        = 1'b0;
        load_ir        = 1'b0;
        load_regfile   = 1'b0;
        load_mar       = 1'b0;
        load_mdr       = 1'b0;
        load_data_out  = 1'b0;
        pcmux_sel      = pcmux_pc_plus4;
        regfilemux_sel = rfmux_alu_out;
        marmux_sel     = marmux_pc_out;
        alumux1_sel    = alumux1_rs1_out;
        alumux2_sel    = alumux2_i_imm;
        cmpmux_sel     = cmpmux_rs2_out;
        aluop          = alu_add;
        cmpop          = branch_funct3_t'(funct3);
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.read_mask  = '0;
        bus.write_mask = '0;

        case (state)
            FETCH1: begin
                marmux_sel = marmux_pc_out;
                load_mar   = 1'b1;
                next_state = FETCH2;
            end
            FETCH2: begin
                bus.mem_read = 1'b1;
                load_mdr     = 1'b1;
                if (bus.mem_resp) next_state = FETCH3;
            end
            FETCH3: begin
                load_ir    = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                case (opcode)
                    op_imm:   next_state = IMM;
                    op_reg:   next_state = REG;
                    op_lui:   next_state = LUI;
                    op_auipc: next_state = AUIPC;
                    op_br:    next_state = BR;
                    op_load:  next_state = CALC_LD;
                    op_store: next_state = CALC_ST;
                    op_jal:   next_state = JAL;
                    op_jalr:  next_state = JALR;
                    default: begin
                        load_pc    = 1'b1;
                        pcmux_sel  = pcmux_pc_plus4;
                        next_state = FETCH1;
                    end
                endcase
            end
            IMM, REG: begin
                alumux1_sel    = alumux1_rs1_out;
                alumux2_sel    = (state == REG) ? alumux2_rs2_out : alumux2_i_imm;
                regfilemux_sel = rfmux_alu_out;
                load_regfile   = 1'b1;
                load_pc        = 1'b1;
                next_state     = FETCH1;
                case (funct3)
                    slt, sltu: begin
                        cmpop          = (funct3 == slt) ? blt : bltu;
                        cmpmux_sel     = (state == REG) ? cmpmux_rs2_out : cmpmux_i_imm;
                        regfilemux_sel = rfmux_br_en;
                    end
                    sr:      aluop = funct7[5] ? alu_sra : alu_srl;
                    add:     aluop = (state == REG && funct7[5]) ? alu_sub : alu_add;
                    default: aluop = alu_ops'(funct3);
                endcase
            end
            LUI: begin
                regfilemux_sel = rfmux_u_imm;
                load_regfile   = 1'b1;
                load_pc        = 1'b1;
                next_state     = FETCH1;
            end
            AUIPC: begin
                alumux1_sel    = alumux1_pc_out;
                alumux2_sel    = alumux2_u_imm;
                regfilemux_sel = rfmux_alu_out;
                load_regfile   = 1'b1;
                load_pc        = 1'b1;
                next_state     = FETCH1;
            end
            BR: begin
                alumux1_sel = alumux1_pc_out;
                alumux2_sel = alumux2_b_imm;
                cmpmux_sel  = cmpmux_rs2_out;
                pcmux_sel   = br_en ? pcmux_alu_out : pcmux_pc_plus4;
                load_pc     = 1'b1;
                next_state  = FETCH1;
            end
            JAL: begin
                alumux1_sel    = alumux1_pc_out;
                alumux2_sel    = alumux2_j_imm;
                regfilemux_sel = rfmux_pc_plus4;
                load_regfile   = 1'b1;
                pcmux_sel      = pcmux_alu_out;
                load_pc        = 1'b1;
                next_state     = FETCH1;
            end
            JALR: begin
                alumux1_sel    = alumux1_rs1_out;
                alumux2_sel    = alumux2_i_imm;
                regfilemux_sel = rfmux_pc_plus4;
                load_regfile   = 1'b1;
                pcmux_sel      = pcmux_alu_mod2;
                load_pc        = 1'b1;
                next_state     = FETCH1;
            end
            CALC_LD: begin
                alumux1_sel = alumux1_rs1_out;
                alumux2_sel = alumux2_i_imm;
                marmux_sel  = marmux_alu_out;
                load_mar    = 1'b1;
                next_state  = LD1;
            end
            CALC_ST: begin
                alumux1_sel   = alumux1_rs1_out;
                alumux2_sel   = alumux2_s_imm;
                marmux_sel    = marmux_alu_out;
                load_mar      = 1'b1;
                load_data_out = 1'b1;
                next_state    = ST1;
            end
            LD1: begin
                bus.mem_read  = 1'b1;
                load_mdr      = 1'b1;
                bus.read_mask = lane_mask(funct3, bus.mem_addr_unaligned[1:0]);
                if (bus.mem_resp) next_state = LD2;
            end
            LD2: begin
                bus.read_mask = lane_mask(funct3, bus.mem_addr_unaligned[1:0]);
                case (funct3)
                    lb:      regfilemux_sel = rfmux_lb;
                    lh:      regfilemux_sel = rfmux_lh;
                    lbu:     regfilemux_sel = rfmux_lbu;
                    lhu:     regfilemux_sel = rfmux_lhu;
                    default: regfilemux_sel = rfmux_lw;
                endcase
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                next_state   = FETCH1;
            end
            ST1: begin
                bus.mem_write  = 1'b1;
                bus.write_mask = lane_mask(funct3, bus.mem_addr_unaligned[1:0]);
                if (bus.mem_resp) next_state = ST2;
            end
            ST2: begin
                load_pc    = 1'b1;
                next_state = FETCH1;
            end
            default: next_state = FETCH1;
        endcase

        // Reset is asynchronous, so strobes and enables drop in the same cycle.
        if (!rst) begin
            load_pc        = 1'b0;
            load_ir        = 1'b0;
            load_regfile   = 1'b0;
            load_mar       = 1'b0;
            load_mdr       = 1'b0;
            load_data_out  = 1'b0;
            bus.mem_read   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.read_mask  = '0;
            bus.write_mask = '0;
        end
    end

endmodule

// File: tb/tb_control.sv
// Directed self-checking bench for the multicycle control unit.
module tb_control;
    import control_pkg::*;

    logic            clk;
    logic            rst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            br_en;
    logic            load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    pcmux_sel_t      pcmux_sel;
    regfilemux_sel_t regfilemux_sel;
    marmux_sel_t     marmux_sel;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    cmpmux_sel_t     cmpmux_sel;
    alu_ops          aluop;
    branch_funct3_t  cmpop;

    int passed = 0;
    int total  = 0;

    control_if bus();

    control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_en(br_en), .bus(bus),
        .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
        .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
        .pcmux_sel(pcmux_sel), .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel),
        .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel), .cmpmux_sel(cmpmux_sel),
        .aluop(aluop), .cmpop(cmpop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(negedge clk);
    endtask

    // Expects to be entered at a negedge in FETCH1; leaves at the DECODE negedge.
    task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input int n_fetch2);
        #1;
        total++;
        if ({load_mar, marmux_sel} !== {1'b1, marmux_pc_out})
            $display("FAIL fetch1: load_mar=%0b marmux=%0d expected 1/%0d", load_mar, marmux_sel, marmux_pc_out);
        else passed++;
        for (int i = 0; i < n_fetch2; i++) begin
            next_cycle;
            bus.mem_resp = (i == n_fetch2 - 1);
            #1;
            total++;
            if ({bus.mem_read, bus.mem_write, load_ir} !== 3'b100)
                $display("FAIL fetch2[%0d]: read/write/load_ir=%b expected 100", i, {bus.mem_read, bus.mem_write, load_ir});
            else passed++;
        end
        next_cycle;
        bus.mem_resp = 1'b0;
        #1;
        total++;
        if ({load_ir, bus.mem_read} !== 2'b10)
            $display("FAIL fetch3: load_ir/mem_read=%b expected 10", {load_ir, bus.mem_read});
        else passed++;
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        next_cycle;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        next_cycle;
        #1;
        total++;
        if ({load_mar, bus.mem_read, load_pc} !== 3'b000)
            $display("FAIL reset_hold: load_mar/mem_read/load_pc=%b expected 000", {load_mar, bus.mem_read, load_pc});
        else passed++;
        next_cycle;
        rst = 1'b1;
        #1;
        total++;
        if ({load_mar, marmux_sel, bus.mem_read} !== {1'b1, marmux_pc_out, 1'b0})
            $display("FAIL reset_release: load_mar=%0b marmux=%0d mem_read=%0b expected 1/0/0", load_mar, marmux_sel, bus.mem_read);
        else passed++;
    endtask

    task automatic test_addi;
        fetch(7'b0010011, 3'b000, 7'h00, 1);
        #1;
        total++;
        if ({load_regfile, load_pc} !== 2'b00)
            $display("FAIL addi_cycle4: load_regfile/load_pc=%b expected 00", {load_regfile, load_pc});
        else passed++;
        next_cycle;
        #1;
        total++;
        if ({load_regfile, load_pc, regfilemux_sel, aluop, pcmux_sel, alumux1_sel, alumux2_sel} !==
            {1'b1, 1'b1, rfmux_alu_out, alu_add, pcmux_pc_plus4, alumux1_rs1_out, alumux2_i_imm})
            $display("FAIL addi_cycle5: ld_rf=%0b ld_pc=%0b rfmux=%0d aluop=%0d pcmux=%0d am1=%0d am2=%0d expected 1 1 0 0 0 0 0",
                     load_regfile, load_pc, regfilemux_sel, aluop, pcmux_sel, alumux1_sel, alumux2_sel);
        else passed++;
        next_cycle;
    endtask

    task automatic test_branch;
        fetch(7'b1100011, 3'b000, 7'h00, 1);
        next_cycle;
        br_en = 1'b1;
        #1;
        total++;
        if ({load_pc, pcmux_sel, alumux1_sel, alumux2_sel, cmpop, cmpmux_sel} !==
            {1'b1, pcmux_alu_out, alumux1_pc_out, alumux2_b_imm, beq, cmpmux_rs2_out})
            $display("FAIL beq_taken: ld_pc=%0b pcmux=%0d am1=%0d am2=%0d cmpop=%0d cmpmux=%0d expected 1 1 1 2 0 0",
                     load_pc, pcmux_sel, alumux1_sel, alumux2_sel, cmpop, cmpmux_sel);
        else passed++;
        br_en = 1'b0;
        #1;
        total++;
        if (pcmux_sel !== pcmux_pc_plus4)
            $display("FAIL beq_not_taken: pcmux=%0d expected %0d", pcmux_sel, pcmux_pc_plus4);
        else passed++;
        next_cycle;
        // Memory answers on the third FETCH2 cycle.
        fetch(7'b1100011, 3'b001, 7'h00, 3);
        next_cycle;
        #1;
        total++;
        if ({load_pc, pcmux_sel, cmpop} !== {1'b1, pcmux_pc_plus4, bne})
            $display("FAIL bne_not_taken: ld_pc=%0b pcmux=%0d cmpop=%0d expected 1 0 1", load_pc, pcmux_sel, cmpop);
        else passed++;
        next_cycle;
    endtask

    task automatic store(input logic [2:0] f3, input logic [1:0] off, input logic [3:0] exp_mask,
                         input int n_st1);
        fetch(7'b0100011, f3, 7'h00, 1);
        bus.mem_addr_unaligned = {28'h1234567, 2'b00, off};
        next_cycle;
        #1;
        total++;
        if ({load_data_out, load_mar, marmux_sel, alumux2_sel, bus.mem_write} !==
            {1'b1, 1'b1, marmux_alu_out, alumux2_s_imm, 1'b0})
            $display("FAIL calc_st: ld_do=%0b ld_mar=%0b marmux=%0d am2=%0d mem_write=%0b expected 1 1 1 3 0",
                     load_data_out, load_mar, marmux_sel, alumux2_sel, bus.mem_write);
        else passed++;
        for (int i = 0; i < n_st1; i++) begin
            next_cycle;
            bus.mem_resp = (i == n_st1 - 1);
            #1;
            total++;
            if ({bus.mem_write, bus.mem_read, bus.write_mask, load_data_out} !== {2'b10, exp_mask, 1'b0})
                $display("FAIL st1_f3_%0d_off%0d: write/read=%b write_mask=%b expected 10 %b",
                         f3, off, {bus.mem_write, bus.mem_read}, bus.write_mask, exp_mask);
            else passed++;
        end
        next_cycle;
        bus.mem_resp = 1'b0;
        #1;
        total++;
        if ({load_pc, pcmux_sel, bus.mem_write, bus.write_mask} !== {1'b1, pcmux_pc_plus4, 1'b0, 4'b0000})
            $display("FAIL st2: ld_pc=%0b pcmux=%0d mem_write=%0b mask=%b expected 1 0 0 0000",
                     load_pc, pcmux_sel, bus.mem_write, bus.write_mask);
        else passed++;
        next_cycle;
    endtask

    task automatic test_store;
        store(3'b000, 2'd3, 4'b1000, 1);
        store(3'b001, 2'd2, 4'b1100, 1);
        store(3'b010, 2'd0, 4'b1111, 2);
    endtask

    task automatic load(input logic [2:0] f3, input logic [1:0] off, input logic [3:0] exp_mask,
                        input regfilemux_sel_t exp_rf);
        fetch(7'b0000011, f3, 7'h00, 1);
        bus.mem_addr_unaligned = {28'hABCDEF0, 2'b00, off};
        next_cycle;
        #1;
        total++;
        if ({load_mar, marmux_sel, alumux2_sel, bus.mem_read} !== {1'b1, marmux_alu_out, alumux2_i_imm, 1'b0})
            $display("FAIL calc_ld: ld_mar=%0b marmux=%0d am2=%0d mem_read=%0b expected 1 1 0 0",
                     load_mar, marmux_sel, alumux2_sel, bus.mem_read);
        else passed++;
        next_cycle;
        bus.mem_resp = 1'b1;
        #1;
        total++;
        if ({bus.mem_read, load_mdr, bus.read_mask, load_regfile} !== {2'b11, exp_mask, 1'b0})
            $display("FAIL ld1_f3_%0d_off%0d: read/mdr=%b read_mask=%b ld_rf=%0b expected 11 %b 0",
                     f3, off, {bus.mem_read, load_mdr}, bus.read_mask, load_regfile, exp_mask);
        else passed++;
        next_cycle;
        bus.mem_resp = 1'b0;
        #1;
        total++;
        if ({load_regfile, load_pc, regfilemux_sel, bus.read_mask, bus.mem_read} !== {2'b11, exp_rf, exp_mask, 1'b0})
            $display("FAIL ld2_f3_%0d: ld_rf/ld_pc=%b rfmux=%0d read_mask=%b mem_read=%0b expected 11 %0d %b 0",
                     f3, {load_regfile, load_pc}, regfilemux_sel, bus.read_mask, bus.mem_read, exp_rf, exp_mask);
        else passed++;
        next_cycle;
    endtask

    task automatic test_load;
        load(3'b100, 2'd1, 4'b0010, rfmux_lbu);
        load(3'b001, 2'd3, 4'b1000, rfmux_lh);
    endtask

    task automatic alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input alu_ops exp_op, input alumux2_sel_t exp_am2, input string name);
        fetch(op, f3, f7, 1);
        next_cycle;
        #1;
        total++;
        if ({aluop, alumux2_sel, regfilemux_sel, load_regfile} !== {exp_op, exp_am2, rfmux_alu_out, 1'b1})
            $display("FAIL %s: aluop=%0d am2=%0d rfmux=%0d ld_rf=%0b expected %0d %0d 0 1",
                     name, aluop, alumux2_sel, regfilemux_sel, load_regfile, exp_op, exp_am2);
        else passed++;
        next_cycle;
    endtask

    task automatic test_alu_ops;
        alu(7'b0110011, 3'b000, 7'h20, alu_sub, alumux2_rs2_out, "sub");
        alu(7'b0110011, 3'b000, 7'h00, alu_add, alumux2_rs2_out, "add");
        alu(7'b0010011, 3'b000, 7'h20, alu_add, alumux2_i_imm, "addi_f7");
        alu(7'b0010011, 3'b101, 7'h20, alu_sra, alumux2_i_imm, "srai");
        alu(7'b0110011, 3'b101, 7'h00, alu_srl, alumux2_rs2_out, "srl");
        alu(7'b0110011, 3'b111, 7'h00, alu_and, alumux2_rs2_out, "and");
        fetch(7'b0010011, 3'b010, 7'h00, 1);
        next_cycle;
        #1;
        total++;
        if ({cmpop, cmpmux_sel, regfilemux_sel, load_regfile, load_pc} != {blt, cmpmux_i_imm, rfmux_br_en, 2'b11})
            $display("FAIL slti: cmpop=%0d cmpmux=%0d rfmux=%0d ld_rf/pc=%b expected 4 1 1 11",
                     cmpop, cmpmux_sel, regfilemux_sel, {load_regfile, load_pc});
        else passed++;
        next_cycle;
        fetch(7'b0110011, 3'b011, 7'h00, 1);
        next_cycle;
        #1;
        total++;
        if ({cmpop, cmpmux_sel, regfilemux_sel} !== {bltu, cmpmux_rs2_out, rfmux_br_en})
            $display("FAIL sltu: cmpop=%0d cmpmux=%0d rfmux=%0d expected 6 0 1", cmpop, cmpmux_sel, regfilemux_sel);
        else passed++;
        next_cycle;
    endtask

    task automatic test_jumps;
        fetch(7'b1101111, 3'b000, 7'h00, 1);
        next_cycle;
        #1;
        total++;
        if ({pcmux_sel, regfilemux_sel, alumux1_sel, alumux2_sel, load_pc, load_regfile} !==
            {pcmux_alu_out, rfmux_pc_plus4, alumux1_pc_out, alumux2_j_imm, 2'b11})
            $display("FAIL jal: pcmux=%0d rfmux=%0d am1=%0d am2=%0d ld=%b expected 1 4 1 4 11",
                     pcmux_sel, regfilemux_sel, alumux1_sel, alumux2_sel, {load_pc, load_regfile});
        else passed++;
        next_cycle;
        fetch(7'b1100111, 3'b000, 7'h00, 1);
        next_cycle;
        #1;
        total++;
        if ({pcmux_sel, regfilemux_sel, alumux1_sel, alumux2_sel} !==
            {pcmux_alu_mod2, rfmux_pc_plus4, alumux1_rs1_out, alumux2_i_imm})
            $display("FAIL jalr: pcmux=%0d rfmux=%0d am1=%0d am2=%0d expected 2 4 0 0",
                     pcmux_sel, regfilemux_sel, alumux1_sel, alumux2_sel);
        else passed++;
        next_cycle;
    endtask

    task automatic test_undefined;
        fetch(7'h7F, 3'b000, 7'h00, 1);
        #1;
        total++;
        if ({load_pc, pcmux_sel, load_regfile} !== {1'b1, pcmux_pc_plus4, 1'b0})
            $display("FAIL undef_decode: ld_pc=%0b pcmux=%0d ld_rf=%0b expected 1 0 0", load_pc, pcmux_sel, load_regfile);
        else passed++;
        next_cycle;
        #1;
        total++;
        if ({load_mar, marmux_sel, load_pc} !== {1'b1, marmux_pc_out, 1'b0})
            $display("FAIL undef_next_fetch1: ld_mar=%0b marmux=%0d ld_pc=%0b expected 1 0 0", load_mar, marmux_sel, load_pc);
        else passed++;
    endtask

    task automatic test_reset_mid_access;
        fetch(7'b0000011, 3'b010, 7'h00, 1);
        next_cycle;
        next_cycle;
        #1;
        total++;
        if ({bus.mem_read, bus.read_mask} !== {1'b1, 4'b1111})
            $display("FAIL ld1_before_reset: mem_read=%0b read_mask=%b expected 1 1111", bus.mem_read, bus.read_mask);
        else passed++;
        #1;
        rst = 1'b0;
        #1;
        total++;
        if ({bus.mem_read, load_mdr, bus.read_mask} !== 6'b000000)
            $display("FAIL reset_mid_ld1: mem_read=%0b ld_mdr=%0b read_mask=%b expected 0 0 0000",
                     bus.mem_read, load_mdr, bus.read_mask);
        else passed++;
        next_cycle;
        rst = 1'b1;
        #1;
        total++;
        if ({load_mar, marmux_sel, bus.mem_read} !== {1'b1, marmux_pc_out, 1'b0})
            $display("FAIL reset_mid_release: ld_mar=%0b marmux=%0d mem_read=%0b expected 1 0 0",
                     load_mar, marmux_sel, bus.mem_read);
        else passed++;
    endtask

    initial begin
        rst = 1'b0;
        opcode = '0;
        funct3 = '0;
        funct7 = '0;
        br_en = 1'b0;
        bus.mem_resp = 1'b0;
        bus.mem_addr_unaligned = '0;
        test_reset;
        test_addi;
        test_branch;
        test_store;
        test_load;
        test_alu_ops;
        test_jumps;
        test_undefined;
        test_reset_mid_access;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
